// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Serialises a parallel word as
// start bit, data LSB first, optional parity bit, then stop bit(s).
// One CLK cycle is one bit period.
// Optional macro UART_TX_TWO_STOP_EN: two stop cycles instead of one.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int             CW   = (DATA_WIDTH > 8) ? 4 : 3;
  localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_q, state_nxt;
  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic [DATA_WIDTH-1:0]   sh_q, sh_nxt;      // latched word, shifted out LSB first
  logic                    par_en_q, par_en_nxt;
  logic                    par_q, par_nxt;    // parity bit, fixed at acceptance
  logic                    tx_q, tx_nxt;
  logic                    busy_q, busy_nxt;

  // state, datapath and registered line outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      sh_q     <= sh_nxt;
      par_en_q <= par_en_nxt;
      par_q    <= par_nxt;
      tx_q     <= tx_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // next-state logic; line value is derived from the next state so that
  // TX_OUT and BUSY come straight from flops and change with the state
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    sh_nxt     = sh_q;
    par_en_nxt = par_en_q;
    par_nxt    = par_q;
    tx_nxt     = 1'b1;
    busy_nxt   = 1'b0;

    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_nxt  = START;
          cnt_nxt    = '0;
          sh_nxt     = P_DATA;
          par_en_nxt = PAR_EN;
          // XOR of data is 1 for an odd count; PAR_TYP flips to odd parity
          par_nxt    = (^P_DATA) ^ PAR_TYP;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
      end
      DATA: begin
        sh_nxt = sh_q >> 1;
        if (cnt_q == LAST) begin
          cnt_nxt   = '0;
          state_nxt = par_en_q ? PARITY : STOP;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        state_nxt = STOP;
        cnt_nxt   = '0;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (cnt_q == CW'(1)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CW'(1);
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      PARITY:  tx_nxt = par_q;
      default: tx_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed + randomized checks of uart_tx_frame against
// a frame-level reference model (expected bit list per request).
module tb_uart_tx_frame;
  localparam int W = 8;
`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] P_DATA = '0;
  logic         DATA_VALID = 1'b0;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic         TX_OUT;
  logic         BUSY;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];

  uart_tx_frame #(.DATA_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits for one frame, from the framing rules directly
  function automatic void build(input logic [W-1:0] d, input logic en, input logic typ);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    if (en) begin
      ones = $countones(d);
      // even: make total count even; odd: make it odd
      exp_q.push_back(((ones % 2) == 1) ^ typ);
    end
    for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
  endfunction

  // Present a request at a falling edge; the next rising edge accepts it
  task automatic request(input logic [W-1:0] d, input logic en, input logic typ);
    @(negedge CLK);
    P_DATA = d; PAR_EN = en; PAR_TYP = typ; DATA_VALID = 1'b1;
  endtask

  // Follow one frame from its accepting edge to the idle cycle after it
  task automatic run_frame(input string tag, input logic [W-1:0] d, input logic en,
                           input logic typ, input bit noisy, input bit noise_ff, input bit hold);
    build(d, en, typ);
    @(posedge CLK); #1;
    if (!hold) DATA_VALID = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx[%0d]", tag, i), {31'd0, TX_OUT}, {31'd0, exp_q[i]});
      chk($sformatf("%s busy[%0d]", tag, i), {31'd0, BUSY}, 32'd1);
      if (noisy) begin
        P_DATA  = noise_ff ? '1 : W'($urandom);
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
        if (!hold) DATA_VALID = (i < exp_q.size() - 2) ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge CLK);
    chk({tag, " idle tx"}, {31'd0, TX_OUT}, 32'd1);
    chk({tag, " idle busy"}, {31'd0, BUSY}, 32'd0);
  endtask

  initial begin
    logic [W-1:0] d;
    logic en, typ;

    // reset state, no clock edge needed
    #1 RST = 1'b0;
    #1;
    chk("reset tx", {31'd0, TX_OUT}, 32'd1);
    chk("reset busy", {31'd0, BUSY}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("post-reset tx", {31'd0, TX_OUT}, 32'd1);
    chk("post-reset busy", {31'd0, BUSY}, 32'd0);

    // A5 even parity, then odd parity
    request(8'hA5, 1'b1, 1'b0);
    run_frame("a5_even", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    request(8'hA5, 1'b1, 1'b1);
    run_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // all zeros, no parity
    request(8'h00, 1'b0, 1'b0);
    run_frame("zero_nopar", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // requests and input changes while busy are ignored
    request(8'h3C, 1'b1, 1'b0);
    run_frame("ignore_busy", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk("ignore_busy no 2nd frame", {31'd0, BUSY}, 32'd0);

    // DATA_VALID held high: back-to-back frames with one idle cycle between
    request(8'h81, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++)
      run_frame($sformatf("b2b%0d", k), 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    DATA_VALID = 1'b0;

    // asynchronous reset in the middle of data bit 4
    request(8'h5A, 1'b1, 1'b0);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    repeat (6) @(negedge CLK);
    chk("pre-reset bit4", {31'd0, TX_OUT}, 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("midframe reset tx", {31'd0, TX_OUT}, 32'd1);
    chk("midframe reset busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("after reset idle busy", {31'd0, BUSY}, 32'd0);
    request(8'hC3, 1'b1, 1'b1);
    run_frame("after_reset", 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // randomized frames, with and without mid-frame input noise
    for (int k = 0; k < 8; k++) begin
      d   = W'($urandom);
      en  = 1'($urandom);
      typ = 1'($urandom);
      request(d, en, typ);
      run_frame($sformatf("rnd%0d", k), d, en, typ, k[0], 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
